join_result_arbiter: RTL and testbench

Collects match results from a chain of `NUM_CORES` join stages and merges them onto one output stream. Each stage's result is captured into a per-stage slot on the cycle its window tuple leaves the stage, and the slots are drained round-robin through a valid/ready output register. The block also generates the common window-flow enable for the chain, stalling the chain whenever a pending result would otherwise be lost. It sits between the join-stage chain and the result writer in the stream join kernel.

---
 rtl/join_result_arbiter.sv | 140 ++++++++++++++
 tb/tb_join_result_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/join_result_arbiter.sv
// Merges per-stage join results onto one valid/ready stream via round-robin slots, and
// generates the chain-wide window flow enable that stalls the chain before a result is lost.
`ifndef PARA_RESULT_PAIR_WIDTH
`define PARA_RESULT_PAIR_WIDTH 17
`endif

module join_result_arbiter #(
    parameter int unsigned NUM_CORES         = 8,
    parameter int unsigned RESULT_PAIR_WIDTH = `PARA_RESULT_PAIR_WIDTH,
    parameter int unsigned ID_WIDTH          = $clog2(NUM_CORES)
) (
    input  logic                                   aclk,
    input  logic                                   ap_rst_n,
    input  logic [NUM_CORES*RESULT_PAIR_WIDTH-1:0] result_pair_in,
    input  logic                                   flow_request,
    output logic                                   window_tuple_flow_enable,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [RESULT_PAIR_WIDTH-2:0]           result_data,
    output logic [ID_WIDTH-1:0]                    result_core_id,
    output logic                                   slots_empty,
    output logic [31:0]                            result_count,
    output logic [31:0]                            stall_count
);
    localparam int NC = int'(NUM_CORES);
    localparam int RW = int'(RESULT_PAIR_WIDTH);
    localparam int PW = RW - 1;

    logic [NC-1:0] in_valid;
    logic [PW-1:0] in_payload [NC];

    logic [NC-1:0]       slot_full_q, slot_full_d;
    logic [PW-1:0]       slot_data_q [NC];
    logic [PW-1:0]       slot_data_d [NC];
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                result_valid_q, result_valid_d;
    logic [PW-1:0]       result_data_q, result_data_d;
    logic [ID_WIDTH-1:0] result_id_q, result_id_d;
    logic [31:0]         result_count_q, result_count_d;
    logic [31:0]         stall_count_q, stall_count_d;

    logic                blocked;
    logic                flow_en;
    logic                any_full;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                out_free;

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            in_valid[i]   = result_pair_in[i*RW + PW];
            in_payload[i] = result_pair_in[i*RW +: PW];
        end
    end

    // Only a new result landing on an already-full slot can lose data.
    assign blocked  = |(in_valid & slot_full_q);
    assign flow_en  = flow_request & ~blocked;
    assign any_full = |slot_full_q;
    assign out_free = ~result_valid_q | result_ready;

    // Pick the full slot with the smallest circular distance from rr_ptr.
    always_comb begin
        int off;
        int best_off;
        off       = 0;
        best_off  = NC;
        grant_idx = '0;
        for (int j = 0; j < NC; j++) begin
            off = j - int'(rr_ptr_q);
            if (off < 0) off += NC;
            if (slot_full_q[j] && (off < best_off)) begin
                best_off  = off;
                grant_idx = ID_WIDTH'(j);
            end
        end
    end

    always_comb begin
        slot_full_d    = slot_full_q;
        slot_data_d    = slot_data_q;
        rr_ptr_d       = rr_ptr_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        result_id_d    = result_id_q;
        result_count_d = result_count_q;
        stall_count_d  = stall_count_q;

        if (out_free) begin
            result_valid_d = any_full;
            if (any_full) begin
                result_data_d          = slot_data_q[grant_idx];
                result_id_d            = grant_idx;
                slot_full_d[grant_idx] = 1'b0;
                rr_ptr_d = (grant_idx == ID_WIDTH'(NC - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
            end
        end

        // Gating guarantees a capturing slot is never the one being drained.
        for (int j = 0; j < NC; j++) begin
            if (flow_en && in_valid[j]) begin
                slot_full_d[j] = 1'b1;
                slot_data_d[j] = in_payload[j];
            end
        end

        if (result_valid_q && result_ready) result_count_d = result_count_q + 32'd1;
        if (flow_request && blocked)        stall_count_d  = stall_count_q + 32'd1;
    end

    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            slot_full_q    <= '0;
            for (int j = 0; j < NC; j++) slot_data_q[j] <= '0;
            rr_ptr_q       <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_id_q    <= '0;
            result_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            slot_full_q    <= slot_full_d;
            slot_data_q    <= slot_data_d;
            rr_ptr_q       <= rr_ptr_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_id_q    <= result_id_d;
            result_count_q <= result_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign window_tuple_flow_enable = flow_en;
    assign result_valid             = result_valid_q;
    assign result_data              = result_data_q;
    assign result_core_id           = result_id_q;
    assign slots_empty              = ~any_full & ~result_valid_q;
    assign result_count             = result_count_q;
    assign stall_count              = stall_count_q;

endmodule

// File: tb/tb_join_result_arbiter.sv
// Bench for join_result_arbiter: scoreboard on the output stream, a flow-gating vector table,
// and directed sequences for latency, round-robin order, stalls, wrap fairness and reset.
module tb_join_result_arbiter;
    localparam int N   = 8;
    localparam int W   = 17;
    localparam int P   = W - 1;
    localparam int IDW = $clog2(N);

    logic           aclk = 1'b0;
    logic           ap_rst_n = 1'b0;
    logic [N*W-1:0] result_pair_in = '0;
    logic           flow_request = 1'b0;
    logic           result_ready = 1'b0;
    logic           window_tuple_flow_enable;
    logic           result_valid;
    logic [P-1:0]   result_data;
    logic [IDW-1:0] result_core_id;
    logic           slots_empty;
    logic [31:0]    result_count;
    logic [31:0]    stall_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [P-1:0]   data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic         flow;
        logic [N-1:0] mask;
        logic         exp_en;
    } vec_t;
    vec_t vecs[7];

    always #5 aclk = ~aclk;

    join_result_arbiter #(
        .NUM_CORES        (N),
        .RESULT_PAIR_WIDTH(W)
    ) dut (
        .aclk                    (aclk),
        .ap_rst_n                (ap_rst_n),
        .result_pair_in          (result_pair_in),
        .flow_request            (flow_request),
        .window_tuple_flow_enable(window_tuple_flow_enable),
        .result_valid            (result_valid),
        .result_ready            (result_ready),
        .result_data             (result_data),
        .result_core_id          (result_core_id),
        .slots_empty             (slots_empty),
        .result_count            (result_count),
        .stall_count             (stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic set_stage(input int i, input logic v, input int pay);
        result_pair_in[i*W +: W] = {v, P'(pay)};
    endtask

    task automatic set_mask(input logic [N-1:0] m, input int base);
        for (int i = 0; i < N; i++) set_stage(i, m[i], base + i);
    endtask

    task automatic push_exp(input int id, input int data);
        exp_t e;
        e.id   = IDW'(id);
        e.data = P'(data);
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || result_valid) && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic reset_dut();
        tick();
        ap_rst_n       = 1'b0;
        flow_request   = 1'b1;
        result_ready   = 1'b0;
        result_pair_in = '0;
        probe();
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_empty", 32'(slots_empty), 32'd1);
        check("rst_flow_en", 32'(window_tuple_flow_enable), 32'd1);
        check("rst_result_count", result_count, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
        sb_q.delete();
        tick();
        ap_rst_n     = 1'b1;
        flow_request = 1'b0;
    endtask

    // Output monitor: a handshake seen here completes on the next rising edge.
    always @(negedge aclk) begin
        if (ap_rst_n && result_valid && result_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got id %0d data 0x%0h, required none",
                         result_core_id, result_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_core_id", 32'(result_core_id), 32'(e.id));
                check("out_data", 32'(result_data), 32'(e.data));
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 8'h04, 1'b0};
        vecs[2] = '{1'b1, 8'h04, 1'b0};
        vecs[3] = '{1'b1, 8'h20, 1'b0};
        vecs[4] = '{1'b1, 8'h01, 1'b1};
        vecs[5] = '{1'b1, 8'hDB, 1'b1};
        vecs[6] = '{1'b1, 8'hFF, 1'b0};

        // Single result: two-edge latency.
        reset_dut();
        result_ready = 1'b1;
        tick();
        flow_request = 1'b1;
        set_stage(3, 1'b1, 'h1234);
        push_exp(3, 'h1234);
        probe();
        check("single_flow_en", 32'(window_tuple_flow_enable), 32'd1);
        tick();
        set_stage(3, 1'b0, 0);
        probe();
        check("single_valid_e0", 32'(result_valid), 32'd0);
        check("single_slot_full", 32'(slots_empty), 32'd0);
        tick();
        probe();
        check("single_valid_e1", 32'(result_valid), 32'd1);
        wait_drain("single");
        check("single_count", result_count, 32'd1);

        // Round-robin: two full bursts, one result per cycle.
        reset_dut();
        result_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tick();
            flow_request = 1'b1;
            set_mask(8'hFF, 'hB000 + b * 'h100);
            for (int i = 0; i < N; i++) push_exp(i, 'hB000 + b * 'h100 + i);
            tick();
            set_mask(8'h00, 0);
            tick();
            for (int k = 0; k < N; k++) begin
                probe();
                check("rr_no_bubble", 32'(result_valid), 32'd1);
                tick();
            end
            wait_drain("rr");
            check("rr_count", result_count, 32'(8 * (b + 1)));
            check("rr_empty", 32'(slots_empty), 32'd1);
        end

        // Flow-gating table with slots 2 and 5 full and slot 0 parked in the output.
        reset_dut();
        tick();
        flow_request = 1'b1;
        set_mask(8'h25, 'hA000);
        push_exp(0, 'hA000);
        push_exp(2, 'hA002);
        push_exp(5, 'hA005);
        tick();
        flow_request = 1'b0;
        set_mask(8'h00, 0);
        tick();
        probe();
        check("tbl_valid", 32'(result_valid), 32'd1);
        check("tbl_not_empty", 32'(slots_empty), 32'd0);
        for (int v = 0; v < 7; v++) begin
            tick();
            flow_request = vecs[v].flow;
            set_mask(vecs[v].mask, 'hE000);
            probe();
            check("tbl_flow_en", 32'(window_tuple_flow_enable), 32'(vecs[v].exp_en));
            flow_request = 1'b0;
            set_mask(8'h00, 0);
        end
        check("tbl_stall_none", stall_count, 32'd0);
        tick();
        result_ready = 1'b1;
        wait_drain("tbl");
        check("tbl_count", result_count, 32'd3);

        // Backpressure stall on stage 2.
        reset_dut();
        tick();
        flow_request = 1'b1;
        set_stage(2, 1'b1, 'h0111);
        push_exp(2, 'h0111);
        probe();
        check("stall_en0", 32'(window_tuple_flow_enable), 32'd1);
        tick();
        set_stage(2, 1'b1, 'h0222);
        probe();
        check("stall_blocked0", 32'(window_tuple_flow_enable), 32'd0);
        check("stall_cnt0", stall_count, 32'd0);
        tick();
        probe();
        check("stall_out_valid", 32'(result_valid), 32'd1);
        check("stall_cnt1", stall_count, 32'd1);
        check("stall_reopen", 32'(window_tuple_flow_enable), 32'd1);
        push_exp(2, 'h0222);
        tick();
        set_stage(2, 1'b1, 'h0333);
        probe();
        check("stall_blocked1", 32'(window_tuple_flow_enable), 32'd0);
        check("stall_cnt1b", stall_count, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            probe();
            check("stall_cnt_inc", stall_count, 32'(k));
            check("stall_held", 32'(window_tuple_flow_enable), 32'd0);
        end
        result_ready = 1'b1;
        tick();
        probe();
        check("stall_resume", 32'(window_tuple_flow_enable), 32'd1);
        check("stall_cnt_final", stall_count, 32'd6);
        push_exp(2, 'h0333);
        tick();
        flow_request = 1'b0;
        set_stage(2, 1'b0, 0);
        wait_drain("stall");
        check("stall_count_results", result_count, 32'd3);

        // Results held without flow are ignored.
        reset_dut();
        result_ready = 1'b1;
        tick();
        set_stage(5, 1'b1, 'h5555);
        repeat (10) tick();
        probe();
        check("hold_flow_en", 32'(window_tuple_flow_enable), 32'd0);
        check("hold_valid", 32'(result_valid), 32'd0);
        check("hold_stall", stall_count, 32'd0);
        check("hold_empty", 32'(slots_empty), 32'd1);
        set_stage(5, 1'b0, 0);

        // Wrap fairness: rr_ptr=6, then slots 7 and 1, then slots 2 and 0.
        reset_dut();
        result_ready = 1'b1;
        tick();
        flow_request = 1'b1;
        set_mask(8'h20, 'hC000);
        push_exp(5, 'hC005);
        tick();
        set_mask(8'h00, 0);
        wait_drain("wrap_setup");
        tick();
        set_mask(8'h82, 'hC100);
        push_exp(7, 'hC107);
        push_exp(1, 'hC101);
        tick();
        set_mask(8'h00, 0);
        wait_drain("wrap");
        tick();
        set_mask(8'h05, 'hC200);
        push_exp(2, 'hC202);
        push_exp(0, 'hC200);
        tick();
        set_mask(8'h00, 0);
        wait_drain("wrap_ptr");
        check("wrap_count", result_count, 32'd5);

        // Asynchronous reset mid-operation discards everything.
        reset_dut();
        tick();
        flow_request = 1'b1;
        set_mask(8'h1F, 'hD000);
        tick();
        set_mask(8'h00, 0);
        tick();
        probe();
        check("mid_valid", 32'(result_valid), 32'd1);
        check("mid_not_empty", 32'(slots_empty), 32'd0);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_data", 32'(result_data), 32'd0);
        check("mid_rst_id", 32'(result_core_id), 32'd0);
        check("mid_rst_empty", 32'(slots_empty), 32'd1);
        check("mid_rst_flow_en", 32'(window_tuple_flow_enable), 32'd1);
        check("mid_rst_count", result_count, 32'd0);
        tick();
        tick();
        ap_rst_n     = 1'b1;
        result_ready = 1'b1;
        repeat (10) tick();
        probe();
        check("mid_no_stale", 32'(result_valid), 32'd0);
        check("mid_empty_after", 32'(slots_empty), 32'd1);
        check("mid_count_after", result_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
